cdb_arbiter: RTL

Common Data Bus arbiter for the Tomasulo core. It sits between the functional units, which produce `{tag, value}` results, and the single result bus that the reservation stations, register status table and register file snoop. Each cycle it grants at most one pending requester in round-robin order. It registers the winner onto the bus and tracks broadcast statistics.

---
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - request/result bus bundle between functional units and the CDB arbiter
interface cdb_arbiter_if #(
  parameter int NUM_UF = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
);
  logic [NUM_UF-1:0]        req;
  logic [NUM_UF*TAG_W-1:0]  req_tag;
  logic [NUM_UF*DATA_W-1:0] req_data;
  logic                     cdb_stall;
  logic                     flush;
  logic [NUM_UF-1:0]        grant;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic [15:0]              bcast_count;
  logic                     err_tag0;

  modport master (
    output req, req_tag, req_data, cdb_stall, flush,
    input  grant, cdb_valid, cdb_tag, cdb_data, bcast_count, err_tag0
  );

  modport slave (
    input  req, req_tag, req_data, cdb_stall, flush,
    output grant, cdb_valid, cdb_tag, cdb_data, bcast_count, err_tag0
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast and statistics
module cdb_arbiter #(
  parameter int NUM_UF = 4,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input logic          Clock,
  input logic          Reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_UF);
  localparam logic [NUM_UF-1:0] ONE_UF = NUM_UF'(1);

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [15:0]       r_bcast_count;
  logic              r_err_tag0;

  logic              w_grant_en;
  logic              w_grant_any;
  logic [NUM_UF-1:0] w_req_hi;
  logic [NUM_UF-1:0] w_pick_hi;
  logic [NUM_UF-1:0] w_pick_all;
  logic [NUM_UF-1:0] w_onehot;
  logic [TAG_W-1:0]  w_win_tag;
  logic [DATA_W-1:0] w_win_data;
  logic [PTR_W-1:0]  w_win_idx;
  logic [PTR_W-1:0]  w_next_ptr;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest one.
  assign w_req_hi    = bus.req & ({NUM_UF{1'b1}} << r_rr_ptr);
  assign w_pick_hi   = w_req_hi & (~w_req_hi + ONE_UF);
  assign w_pick_all  = bus.req & (~bus.req + ONE_UF);
  assign w_onehot    = (|w_req_hi) ? w_pick_hi : w_pick_all;

  assign w_grant_en  = !Reset && !bus.cdb_stall && !bus.flush;
  assign w_grant_any = w_grant_en && (|bus.req);
  assign bus.grant   = w_grant_en ? w_onehot : '0;

  always_comb begin
    w_win_tag  = '0;
    w_win_data = '0;
    w_win_idx  = '0;
    for (int i = 0; i < NUM_UF; i++) begin
      if (w_onehot[i +: 1] == 1'b1) begin
        w_win_tag  = bus.req_tag[i*TAG_W +: TAG_W];
        w_win_data = bus.req_data[i*DATA_W +: DATA_W];
        w_win_idx  = PTR_W'(i);
      end
    end
  end

  assign w_next_ptr = (w_win_idx == PTR_W'(NUM_UF - 1)) ? '0 : w_win_idx + PTR_W'(1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rr_ptr      <= '0;
      r_cdb_valid   <= 1'b0;
      r_cdb_tag     <= '0;
      r_cdb_data    <= '0;
      r_bcast_count <= '0;
      r_err_tag0    <= 1'b0;
    end else if (w_grant_any) begin
      // A tag-0 result is consumed but never broadcast; it only raises the sticky error.
      r_cdb_valid <= (w_win_tag != '0);
      r_cdb_tag   <= w_win_tag;
      r_cdb_data  <= w_win_data;
      r_rr_ptr    <= w_next_ptr;
      if (w_win_tag != '0) begin
        r_bcast_count <= r_bcast_count + 16'd1;
      end else begin
        r_err_tag0 <= 1'b1;
      end
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign bus.cdb_valid   = r_cdb_valid;
  assign bus.cdb_tag     = r_cdb_tag;
  assign bus.cdb_data    = r_cdb_data;
  assign bus.bcast_count = r_bcast_count;
  assign bus.err_tag0    = r_err_tag0;
endmodule
